// File: rtl/plugboard.sv
// Steckerbrett: swaps one ASCII letter through a programmable symmetric pair table; 2-cycle latency, 1 char per 3 cycles.
// ready is high only in IDLE; valid while busy is dropped. Optional lowercase folding via PLUGBOARD_LOWERCASE_EN.
module plugboard #(
  parameter int         MAX_PAIRS   = 13,
  parameter logic [7:0] LETTER_BASE = 8'd65
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       set,
  input  logic       pair_wr,
  input  logic [7:0] pair_a,
  input  logic [7:0] pair_b,
  input  logic       clr,
  input  logic       valid,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       done,
  output logic       ready,
  output logic [3:0] pair_cnt,
  output logic       cfg_err,
  output logic       char_err
);

  typedef enum logic [1:0] {IDLE, CFG, XLAT, DONE} state_t;

  state_t      r_state, w_next;
  logic [4:0]  r_table [26];
  logic [7:0]  r_char;
  logic        r_err_armed;
  logic [7:0]  r_dout;
  logic [3:0]  r_pair_cnt;
  logic        r_cfg_err;

  function automatic logic [7:0] f_fold(input logic [7:0] c);
`ifdef PLUGBOARD_LOWERCASE_EN
    if (c >= 8'd97 && c <= 8'd122) return c - 8'd32;
`endif
    return c;
  endfunction

  function automatic logic f_is_letter(input logic [7:0] c);
    return (c >= LETTER_BASE) && (c <= LETTER_BASE + 8'd25);
  endfunction

  logic [7:0] w_a, w_b;
  logic       w_a_ok, w_b_ok, w_pair_ok, w_char_ok;
  logic [4:0] w_ia, w_ib, w_ic;

  // Out-of-range letters are steered to index 0 so the table is never read out of bounds.
  always_comb begin
    w_a       = f_fold(pair_a);
    w_b       = f_fold(pair_b);
    w_a_ok    = f_is_letter(w_a);
    w_b_ok    = f_is_letter(w_b);
    w_ia      = w_a_ok ? 5'(w_a - LETTER_BASE) : 5'd0;
    w_ib      = w_b_ok ? 5'(w_b - LETTER_BASE) : 5'd0;
    w_char_ok = f_is_letter(r_char);
    w_ic      = w_char_ok ? 5'(r_char - LETTER_BASE) : 5'd0;
    w_pair_ok = w_a_ok && w_b_ok && (w_a != w_b) &&
                (r_table[w_ia] == w_ia) && (r_table[w_ib] == w_ib) &&
                (r_pair_cnt < 4'(MAX_PAIRS));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (set)        w_next = CFG;
        else if (valid) w_next = XLAT;
      end
      CFG:  if (!set) w_next = IDLE;
      XLAT: w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 26; i++) r_table[i] <= 5'(i);
      r_char      <= 8'd0;
      r_err_armed <= 1'b0;
      r_dout      <= 8'd0;
      r_pair_cnt  <= 4'd0;
      r_cfg_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (!set && valid) r_char <= f_fold(din);
        CFG: begin
          if (clr) begin
            for (int i = 0; i < 26; i++) r_table[i] <= 5'(i);
            r_pair_cnt <= 4'd0;
            r_cfg_err  <= 1'b0;
          end else if (pair_wr) begin
            if (w_pair_ok) begin
              r_table[w_ia] <= w_ib;
              r_table[w_ib] <= w_ia;
              r_pair_cnt    <= r_pair_cnt + 4'd1;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        XLAT: begin
          if (w_char_ok) begin
            r_dout      <= {3'b000, r_table[w_ic]} + LETTER_BASE;
            r_err_armed <= 1'b0;
          end else begin
            r_dout      <= r_char;
            r_err_armed <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout     = r_dout;
  assign done     = (r_state == DONE);
  assign char_err = (r_state == DONE) && r_err_armed;
  assign ready    = (r_state == IDLE);
  assign pair_cnt = r_pair_cnt;
  assign cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_plugboard.sv
// Directed self-checking bench for plugboard: pairing, rejection rules, latency, reset and drop behaviour.
module tb_plugboard;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       set = 1'b0, pair_wr = 1'b0, clr = 1'b0, valid = 1'b0;
  logic [7:0] pair_a = 8'd0, pair_b = 8'd0, din = 8'd0;
  logic [7:0] dout;
  logic       done, ready, cfg_err, char_err;
  logic [3:0] pair_cnt;

  int n_chk = 0;
  int n_err = 0;

  plugboard dut (
    .clk(clk), .reset_n(reset_n), .set(set), .pair_wr(pair_wr),
    .pair_a(pair_a), .pair_b(pair_b), .clr(clr), .valid(valid),
    .din(din), .dout(dout), .done(done), .ready(ready),
    .pair_cnt(pair_cnt), .cfg_err(cfg_err), .char_err(char_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one char from IDLE; expects exactly one done, one cycle after acceptance.
  task automatic xlat(input string tag, input logic [7:0] c, input logic [7:0] exp, input logic exp_err);
    int n_done = 0;
    int first = -1;
    logic [7:0] got = 8'd0;
    logic       gerr = 1'b0;
    valid = 1'b1; din = c;
    tick();
    valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) begin
        if (first < 0) begin first = i; got = dout; gerr = char_err; end
        n_done++;
      end
    end
    chk({tag, "_dout"}, got, exp);
    chk({tag, "_err"}, gerr, exp_err);
    chk({tag, "_ndone"}, n_done, 1);
    chk({tag, "_lat"}, first, 0);
  endtask

  task automatic cfg_enter();
    set = 1'b1;
    tick();
  endtask

  task automatic cfg_exit();
    set = 1'b0;
    tick();
  endtask

  task automatic wr_pair(input logic [7:0] a, input logic [7:0] b);
    pair_wr = 1'b1; pair_a = a; pair_b = b;
    tick();
    pair_wr = 1'b0;
  endtask

  initial begin
    int n_done;
    #12;
    chk("rst_dout", dout, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", ready, 1);
    chk("rst_cnt", pair_cnt, 0);
    chk("rst_cfgerr", cfg_err, 0);
    chk("rst_charerr", char_err, 0);
    reset_n = 1'b1;
    tick();

    // 1: identity pass-through
    xlat("t1_Q", 8'd81, 8'd81, 1'b0);
    chk("t1_cnt", pair_cnt, 0);

    // 2: A-Z and E-T
    cfg_enter();
    chk("t2_ready_cfg", ready, 0);
    wr_pair("A", "Z");
    wr_pair("E", "T");
    cfg_exit();
    chk("t2_cnt", pair_cnt, 2);
    chk("t2_cfgerr", cfg_err, 0);
    xlat("t2_A", "A", "Z", 1'b0);
    xlat("t2_Z", "Z", "A", 1'b0);
    xlat("t2_E", "E", "T", 1'b0);
    xlat("t2_T", "T", "E", 1'b0);
    xlat("t2_B", "B", "B", 1'b0);

    // 3: rejection rules, then clear
    cfg_enter();
    clr = 1'b1; tick(); clr = 1'b0;
    wr_pair("A", "Z");
    chk("t3_ok_err", cfg_err, 0);
    wr_pair("A", "B");
    chk("t3_plugged_err", cfg_err, 1);
    wr_pair("C", "C");
    wr_pair("1", "D");
`ifndef PLUGBOARD_LOWERCASE_EN
    wr_pair("f", "G");
`endif
    chk("t3_cnt", pair_cnt, 1);
    cfg_exit();
    xlat("t3_A", "A", "Z", 1'b0);
    xlat("t3_B", "B", "B", 1'b0);
    xlat("t3_C", "C", "C", 1'b0);
    xlat("t3_D", "D", "D", 1'b0);
    xlat("t3_F", "F", "F", 1'b0);
    chk("t3_err_sticky", cfg_err, 1);
    cfg_enter();
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t3_clr_err", cfg_err, 0);
    chk("t3_clr_cnt", pair_cnt, 0);
    cfg_exit();
    xlat("t3_A_id", "A", "A", 1'b0);

    // 4: full table and overflow; clr beats pair_wr
    cfg_enter();
    for (int i = 0; i < 13; i++) wr_pair(8'(65 + 2 * i), 8'(66 + 2 * i));
    chk("t4_cnt13", pair_cnt, 13);
    chk("t4_err13", cfg_err, 0);
    wr_pair("A", "C");
    chk("t4_cnt14", pair_cnt, 13);
    chk("t4_err14", cfg_err, 1);
    cfg_exit();
    xlat("t4_M", "M", "N", 1'b0);
    xlat("t4_Z", "Z", "Y", 1'b0);
    cfg_enter();
    clr = 1'b1; pair_wr = 1'b1; pair_a = "A"; pair_b = "Q";
    tick();
    clr = 1'b0; pair_wr = 1'b0;
    chk("t4_clrwr_cnt", pair_cnt, 0);
    chk("t4_clrwr_err", cfg_err, 0);
    cfg_exit();
    xlat("t4_A_id", "A", "A", 1'b0);
    xlat("t4_Q_id", "Q", "Q", 1'b0);

    // 5: non-letter, and valid held into the busy cycle
    xlat("t5_space", 8'd32, 8'd32, 1'b1);
    n_done = 0;
    valid = 1'b1; din = "K";
    tick();
    chk("t5_busy_ready", ready, 0);
    din = "L";
    tick();
    if (done) n_done++;
    chk("t5_dout", dout, "K");
    valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) n_done++;
    end
    chk("t5_ndone", n_done, 1);

    // 6: set wins over valid
    n_done = 0;
    set = 1'b1; valid = 1'b1; din = "R";
    tick();
    valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) n_done++;
    end
    chk("t6_set_ndone", n_done, 0);
    chk("t6_set_ready", ready, 0);
    wr_pair("A", "Z");
    cfg_exit();
    chk("t6_cnt", pair_cnt, 1);

    // 6: reset during XLAT
    valid = 1'b1; din = "A";
    tick();
    valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_done", done, 0);
    chk("t6_rst_dout", dout, 0);
    chk("t6_rst_ready", ready, 1);
    chk("t6_rst_cnt", pair_cnt, 0);
    chk("t6_rst_cfgerr", cfg_err, 0);
    tick();
    reset_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) n_done++;
    end
    chk("t6_rst_ndone", n_done, 0);
    xlat("t6_rst_A_id", "A", "A", 1'b0);

`ifdef PLUGBOARD_LOWERCASE_EN
    xlat("t6_lower_a", "a", "A", 1'b0);
`else
    xlat("t6_lower_a", "a", "a", 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
